// File: rtl/alarm_sequencer.sv
// alarm_sequencer
// ---------------
// Clocked controller for the alarm clock. Holds the alarm time in BCD,
// selects the edit field, edits the alarm digits, and runs the
// arm / ring / snooze state machine off a one-cycle-per-second tick.
//
// Optional feature macro: ALARM_SNOOZE_EN
//   defined     -> SNOOZE state and a 16-bit snooze counter exist.
//   not defined -> snooze_key is ignored, snoozing is tied to 0 and
//                  ringing ends only by timeout or arm_key.
//
// Ports
//   clk, reset           system clock, synchronous active-high reset
//   sec_tick             one-cycle pulse per second
//   left_key, right_key  field select step back / forward (one-cycle pulses)
//   up_key               increment the selected alarm field
//   arm_key              arm / disarm / dismiss / cancel snooze
//   snooze_key           snooze while ringing
//   cur_*                current time, BCD; must already show the new
//                        second in the cycle sec_tick is high
//   field                edit field: 0 = sec, 1 = min, 2 = hour
//   alm_*                alarm time, BCD
//   armed                state is ARMED, RINGING or SNOOZE
//   ringing, snoozing    state is RINGING / SNOOZE
//   beep                 blinking indicator, toggles each second while ringing
//   state_dbg            raw FSM state (0 DISARMED, 1 ARMED, 2 RINGING, 3 SNOOZE)
//
// Handshakes: there are none. Every key and tick input is a single-cycle
// pulse that is acted on at the edge where it is sampled high; no ready or
// acknowledge is returned. All effects appear right after that edge.
//
// Same-cycle priority inside the FSM: arm_key > snooze_key > sec_tick.
// Alarm editing is independent of the FSM and allowed in every state.

module alarm_sequencer #(
    parameter int RING_SECONDS   = 60,
    parameter int SNOOZE_SECONDS = 300
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sec_tick,
    input  logic       left_key,
    input  logic       right_key,
    input  logic       up_key,
    input  logic       arm_key,
    input  logic       snooze_key,
    input  logic [3:0] cur_sec_msb,
    input  logic [3:0] cur_sec_lsb,
    input  logic [3:0] cur_min_msb,
    input  logic [3:0] cur_min_lsb,
    input  logic [3:0] cur_hour_msb,
    input  logic [3:0] cur_hour_lsb,
    output logic [1:0] field,
    output logic [3:0] alm_sec_msb,
    output logic [3:0] alm_sec_lsb,
    output logic [3:0] alm_min_msb,
    output logic [3:0] alm_min_lsb,
    output logic [3:0] alm_hour_msb,
    output logic [3:0] alm_hour_lsb,
    output logic       armed,
    output logic       ringing,
    output logic       snoozing,
    output logic       beep,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        ST_DISARMED = 2'd0,
        ST_ARMED    = 2'd1,
        ST_RINGING  = 2'd2,
        ST_SNOOZE   = 2'd3
    } state_t;

    localparam logic [15:0] RING_LOAD = 16'(RING_SECONDS);

    state_t      state_q, state_d;
    logic [1:0]  field_q, field_d;
    logic [3:0]  alm_sec_msb_q, alm_sec_msb_d;
    logic [3:0]  alm_sec_lsb_q, alm_sec_lsb_d;
    logic [3:0]  alm_min_msb_q, alm_min_msb_d;
    logic [3:0]  alm_min_lsb_q, alm_min_lsb_d;
    logic [3:0]  alm_hour_msb_q, alm_hour_msb_d;
    logic [3:0]  alm_hour_lsb_q, alm_hour_lsb_d;
    logic [15:0] ring_cnt_q, ring_cnt_d;
    logic        beep_q, beep_d;
    logic        alarm_match;

`ifdef ALARM_SNOOZE_EN
    localparam logic [15:0] SNOOZE_LOAD = 16'(SNOOZE_SECONDS);
    logic [15:0] snooze_cnt_q, snooze_cnt_d;
`else
    // Snooze hardware is absent; these inputs intentionally go nowhere.
    logic unused_snooze;
    assign unused_snooze = ^{snooze_key, 32'(SNOOZE_SECONDS)};
`endif

    // Increment a 00..59 BCD pair with wrap, no carry out.
    function automatic logic [7:0] inc_bcd60(input logic [3:0] msb, input logic [3:0] lsb);
        if (lsb == 4'd9) begin
            if (msb == 4'd5) return 8'h00;
            return {msb + 4'd1, 4'd0};
        end
        return {msb, lsb + 4'd1};
    endfunction

    // Increment a 00..23 BCD pair with wrap.
    function automatic logic [7:0] inc_bcd24(input logic [3:0] msb, input logic [3:0] lsb);
        if (msb == 4'd2 && lsb == 4'd3) return 8'h00;
        if (lsb == 4'd9) return {msb + 4'd1, 4'd0};
        return {msb, lsb + 4'd1};
    endfunction

    // Compare uses the registered alarm, so an edit in the same cycle as a
    // tick does not affect that tick's match.
    assign alarm_match = (cur_sec_msb  == alm_sec_msb_q)  && (cur_sec_lsb  == alm_sec_lsb_q)  &&
                         (cur_min_msb  == alm_min_msb_q)  && (cur_min_lsb  == alm_min_lsb_q)  &&
                         (cur_hour_msb == alm_hour_msb_q) && (cur_hour_lsb == alm_hour_lsb_q);

    // Field selector and alarm editing.
    always_comb begin
        field_d        = field_q;
        alm_sec_msb_d  = alm_sec_msb_q;
        alm_sec_lsb_d  = alm_sec_lsb_q;
        alm_min_msb_d  = alm_min_msb_q;
        alm_min_lsb_d  = alm_min_lsb_q;
        alm_hour_msb_d = alm_hour_msb_q;
        alm_hour_lsb_d = alm_hour_lsb_q;

        if (right_key && !left_key) begin
            field_d = (field_q == 2'd2) ? 2'd0 : field_q + 2'd1;
        end else if (left_key && !right_key) begin
            field_d = (field_q == 2'd0) ? 2'd2 : field_q - 2'd1;
        end

        if (up_key) begin
            case (field_q)
                2'd0:    {alm_sec_msb_d, alm_sec_lsb_d}   = inc_bcd60(alm_sec_msb_q, alm_sec_lsb_q);
                2'd1:    {alm_min_msb_d, alm_min_lsb_d}   = inc_bcd60(alm_min_msb_q, alm_min_lsb_q);
                2'd2:    {alm_hour_msb_d, alm_hour_lsb_d} = inc_bcd24(alm_hour_msb_q, alm_hour_lsb_q);
                default: ;
            endcase
        end
    end

    // Alarm state machine: next state, counters and beep.
    always_comb begin
        state_d    = state_q;
        ring_cnt_d = ring_cnt_q;
        beep_d     = beep_q;
`ifdef ALARM_SNOOZE_EN
        snooze_cnt_d = snooze_cnt_q;
`endif

        case (state_q)
            ST_DISARMED: begin
                beep_d = 1'b0;
                if (arm_key) state_d = ST_ARMED;
            end

            ST_ARMED: begin
                beep_d = 1'b0;
                if (arm_key) begin
                    state_d = ST_DISARMED;
                end else if (sec_tick && alarm_match) begin
                    state_d    = ST_RINGING;
                    ring_cnt_d = RING_LOAD;
                    beep_d     = 1'b1;
                end
            end

            ST_RINGING: begin
                if (arm_key) begin
                    state_d = ST_ARMED;
                    beep_d  = 1'b0;
                end
`ifdef ALARM_SNOOZE_EN
                else if (snooze_key) begin
                    state_d      = ST_SNOOZE;
                    snooze_cnt_d = SNOOZE_LOAD;
                    beep_d       = 1'b0;
                end
`endif
                else if (sec_tick) begin
                    // The matching tick is not counted, so the tick that
                    // sees 1 is the RING_SECONDS-th one after it.
                    ring_cnt_d = ring_cnt_q - 16'd1;
                    if (ring_cnt_q == 16'd1) begin
                        state_d = ST_ARMED;
                        beep_d  = 1'b0;
                    end else begin
                        beep_d = ~beep_q;
                    end
                end
            end

`ifdef ALARM_SNOOZE_EN
            ST_SNOOZE: begin
                beep_d = 1'b0;
                if (arm_key) begin
                    state_d = ST_ARMED;
                end else if (sec_tick) begin
                    snooze_cnt_d = snooze_cnt_q - 16'd1;
                    if (snooze_cnt_q == 16'd1) begin
                        state_d    = ST_RINGING;
                        ring_cnt_d = RING_LOAD;
                        beep_d     = 1'b1;
                    end
                end
            end
`endif

            default: begin
                state_d = ST_DISARMED;
                beep_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_DISARMED;
            field_q        <= 2'd0;
            alm_sec_msb_q  <= 4'd0;
            alm_sec_lsb_q  <= 4'd0;
            alm_min_msb_q  <= 4'd0;
            alm_min_lsb_q  <= 4'd0;
            alm_hour_msb_q <= 4'd0;
            alm_hour_lsb_q <= 4'd0;
            ring_cnt_q     <= 16'd0;
            beep_q         <= 1'b0;
`ifdef ALARM_SNOOZE_EN
            snooze_cnt_q   <= 16'd0;
`endif
        end else begin
            state_q        <= state_d;
            field_q        <= field_d;
            alm_sec_msb_q  <= alm_sec_msb_d;
            alm_sec_lsb_q  <= alm_sec_lsb_d;
            alm_min_msb_q  <= alm_min_msb_d;
            alm_min_lsb_q  <= alm_min_lsb_d;
            alm_hour_msb_q <= alm_hour_msb_d;
            alm_hour_lsb_q <= alm_hour_lsb_d;
            ring_cnt_q     <= ring_cnt_d;
            beep_q         <= beep_d;
`ifdef ALARM_SNOOZE_EN
            snooze_cnt_q   <= snooze_cnt_d;
`endif
        end
    end

    assign field        = field_q;
    assign alm_sec_msb  = alm_sec_msb_q;
    assign alm_sec_lsb  = alm_sec_lsb_q;
    assign alm_min_msb  = alm_min_msb_q;
    assign alm_min_lsb  = alm_min_lsb_q;
    assign alm_hour_msb = alm_hour_msb_q;
    assign alm_hour_lsb = alm_hour_lsb_q;
    assign armed        = (state_q != ST_DISARMED);
    assign ringing      = (state_q == ST_RINGING);
`ifdef ALARM_SNOOZE_EN
    assign snoozing     = (state_q == ST_SNOOZE);
`else
    assign snoozing     = 1'b0;
`endif
    assign beep         = beep_q;
    assign state_dbg    = state_q;

endmodule
